drum_pattern_sequencer: RTL and testbench

Parametrised record/playback engine for the drum path. It timestamps key-press onsets on `NUM_VOICES` drum inputs into an internal event RAM and replays them in time order to the drum sound generator through a valid/ready trigger handshake. Compared with the single-voice-per-cycle handler it replaces, it adds:
- configurable voice count, depth and timestamp width;
- simultaneous-onset capture;
- O(1) clear;
- loop playback;
- explicit overflow reporting.

---
 rtl/drum_pattern_sequencer_pkg.sv | 18 +
 rtl/drum_pattern_sequencer_if.sv | 12 +
 rtl/drum_event_ram.sv | 26 ++
 rtl/drum_pattern_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_drum_pattern_sequencer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/drum_pattern_sequencer_pkg.sv
// Shared encodings for the drum pattern sequencer: mode values driven by the
// host and the FSM state type, so RTL and benches agree on them.
package drum_pattern_sequencer_pkg;

    localparam logic [1:0] SEQ_STOP = 2'd0;
    localparam logic [1:0] SEQ_REC  = 2'd1;
    localparam logic [1:0] SEQ_PLAY = 2'd2;
    localparam logic [1:0] SEQ_LOOP = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_REC        = 3'd1,
        ST_PLAY_FETCH = 3'd2,
        ST_PLAY_WAIT  = 3'd3,
        ST_PLAY_EMIT  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/drum_pattern_sequencer_if.sv
// Trigger handshake towards the drum sound generator: the sequencer is the
// master (offers voice events), the sound generator is the slave.
interface drum_pattern_sequencer_if #(
    parameter int VOICE_W = 2
);
    logic               trig_valid;
    logic [VOICE_W-1:0] trig_voice;
    logic               trig_ready;

    modport master (output trig_valid, output trig_voice, input trig_ready);
    modport slave  (input trig_valid, input trig_voice, output trig_ready);
endinterface

// File: rtl/drum_event_ram.sv
// Simple dual-port event RAM (one write, one read port) with a registered
// read: data for the address presented with rd_en_i appears one cycle later.
module drum_event_ram #(
    parameter int DATA_W = 31,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // NOTE: neither the array nor the read register has a reset; a reset
    // would prevent mapping onto a block RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
        if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
    end

endmodule

// File: rtl/drum_pattern_sequencer.sv
// Record/playback engine: timestamps key onsets into the event RAM and replays
// them in time order over the trigger handshake, optionally looping.
module drum_pattern_sequencer
    import drum_pattern_sequencer_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int DEPTH      = 128,
    parameter int TS_WIDTH   = 29,
    parameter int VOICE_W    = $clog2(NUM_VOICES),
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    input  logic [1:0]               mode,
    input  logic                     start,
    input  logic [NUM_VOICES-1:0]    key_down,
    drum_pattern_sequencer_if.master trig_if,
    output logic [ADDR_W:0]          event_count,
    output logic                     overflow,
    output logic                     busy
);

    localparam int              DATA_W    = VOICE_W + TS_WIDTH;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    seq_state_t            state_q, state_d;
    logic [NUM_VOICES-1:0] key_prev_q, pend_q, pend_d;
    logic [TS_WIDTH-1:0]   ts_q;
    logic [TS_WIDTH-1:0]   ts_lat_q [NUM_VOICES];
    logic [ADDR_W:0]       cnt_q, cnt_d, ptr_q, ptr_d, ptr_inc;
    logic                  ovf_q, ovf_d, loop_q, loop_d;
    logic                  ts_clr, wr_en, rd_en, trig_valid;

    logic [NUM_VOICES-1:0] onset, pend_all;
    logic                  grant_vld;
    logic [VOICE_W-1:0]    grant_idx;
    logic [TS_WIDTH-1:0]   grant_ts;
    logic [DATA_W-1:0]     rd_data;
    logic [VOICE_W-1:0]    ent_voice;
    logic [TS_WIDTH-1:0]   ent_ts;

    assign onset     = key_down & ~key_prev_q;
    assign pend_all  = pend_q | onset;
    assign ptr_inc   = ptr_q + 1'b1;
    assign ent_voice = rd_data[DATA_W-1 -: VOICE_W];
    assign ent_ts    = rd_data[TS_WIDTH-1:0];

    // Lowest pending voice wins; a voice whose onset is this cycle uses the live count.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (pend_all[i]) begin
                grant_vld = 1'b1;
                grant_idx = VOICE_W'(i);
            end
        end
        grant_ts = onset[grant_idx] ? ts_q : ts_lat_q[grant_idx];
    end

    // NOTE: registers take non-blocking assignments; the combinational
    // next-state block below uses blocking ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            key_prev_q <= '0;
            pend_q     <= '0;
            ts_q       <= '0;
            cnt_q      <= '0;
            ptr_q      <= '0;
            ovf_q      <= 1'b0;
            loop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_prev_q <= key_down;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            ovf_q      <= ovf_d;
            loop_q     <= loop_d;
            if (ts_clr)                 ts_q <= '0;
            else if (tick && !(&ts_q))  ts_q <= ts_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (onset[v]) ts_lat_q[v] <= ts_q;
        end
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no
        // path through the case can infer a latch.
        state_d    = state_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        ovf_d      = ovf_q;
        loop_d     = loop_q;
        ts_clr     = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        trig_valid = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                pend_d = '0;
                if (start && mode == SEQ_REC) begin
                    state_d = ST_REC;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    ts_clr  = 1'b1;
                end else if (start && (mode == SEQ_PLAY || mode == SEQ_LOOP) && cnt_q != '0) begin
                    state_d = ST_PLAY_FETCH;
                    ptr_d   = '0;
                    ts_clr  = 1'b1;
                    loop_d  = (mode == SEQ_LOOP);
                end
            end
            ST_REC: begin
                if (mode != SEQ_REC) begin
                    state_d = ST_IDLE;
                    pend_d  = '0;
                end else begin
                    pend_d = pend_all;
                    if (grant_vld) begin
                        pend_d[grant_idx] = 1'b0;
                        if (cnt_q == DEPTH_CNT) begin
                            ovf_d = 1'b1;
                        end else begin
                            wr_en = 1'b1;
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            ST_PLAY_FETCH: begin
                rd_en   = 1'b1;
                state_d = ST_PLAY_WAIT;
            end
            ST_PLAY_WAIT: begin
                if (ts_q >= ent_ts) state_d = ST_PLAY_EMIT;
            end
            ST_PLAY_EMIT: begin
                trig_valid = 1'b1;
                if (trig_if.trig_ready) begin
                    state_d = ST_PLAY_FETCH;
                    ptr_d   = ptr_inc;
                    if (ptr_inc == cnt_q) begin
                        if (loop_q) begin
                            ptr_d  = '0;
                            ts_clr = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Stop aborts playback from any play state, including mid-emit.
        if (mode == SEQ_STOP && state_q inside {ST_PLAY_FETCH, ST_PLAY_WAIT, ST_PLAY_EMIT})
            state_d = ST_IDLE;
    end

    drum_event_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (cnt_q[ADDR_W-1:0]),
        .wr_data_i ({grant_idx, grant_ts}),
        .rd_en_i   (rd_en),
        .rd_addr_i (ptr_q[ADDR_W-1:0]),
        .rd_data_o (rd_data)
    );

    assign trig_if.trig_valid = trig_valid;
    assign trig_if.trig_voice = trig_valid ? ent_voice : '0;
    assign event_count        = cnt_q;
    assign overflow           = ovf_q;
    assign busy               = (state_q != ST_IDLE);

endmodule

// File: tb/tb_drum_pattern_sequencer.sv
// Directed bench for drum_pattern_sequencer (4 voices, 4-entry RAM, 8-bit
// timestamps): record, playback timing, overflow, backpressure, loop, aborts.
module tb_drum_pattern_sequencer;
    import drum_pattern_sequencer_pkg::*;

    localparam int NV    = 4;
    localparam int DEPTH = 4;
    localparam int TSW   = 8;
    localparam int VW    = 2;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          reset, tick, start;
    logic [1:0]    mode;
    logic [NV-1:0] key_down;
    logic [AW:0]   event_count;
    logic          overflow, busy;

    drum_pattern_sequencer_if #(.VOICE_W(VW)) trig_if ();

    drum_pattern_sequencer #(
        .NUM_VOICES (NV),
        .DEPTH      (DEPTH),
        .TS_WIDTH   (TSW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .mode        (mode),
        .start       (start),
        .key_down    (key_down),
        .trig_if     (trig_if),
        .event_count (event_count),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int ev_voice[$];
    int ev_cyc[$];
    bit play_timeout;

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_mode(input logic [1:0] m);
        mode  = m;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // Starts playback and logs every accepted handshake with its cycle index
    // (cycle 0 = first cycle after the start edge).
    task automatic run_play(input logic [1:0] m, input int max_ev, input int budget);
        ev_voice.delete();
        ev_cyc.delete();
        play_timeout = 1'b0;
        start_mode(m);
        for (int c = 0; c < budget; c++) begin
            if (c > 0) cyc();
            if (trig_if.trig_valid && trig_if.trig_ready) begin
                ev_voice.push_back(int'(trig_if.trig_voice));
                ev_cyc.push_back(c);
            end
            if (ev_voice.size() == max_ev || !busy) return;
        end
        play_timeout = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; tick = 1'b1; start = 1'b0; mode = SEQ_STOP; key_down = '0;
        trig_if.trig_ready = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        n_tests++;
        if ({busy, trig_if.trig_valid, trig_if.trig_voice, event_count, overflow} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b valid=%b voice=%0d count=%0d ovf=%b expected all 0",
                     busy, trig_if.trig_valid, trig_if.trig_voice, event_count, overflow);
        end
    endtask

    task automatic test_single();
        int exp_v[2] = '{2, 0};
        int exp_c[2] = '{11, 26};
        start_mode(SEQ_REC);
        repeat (10) cyc();
        key_down[2] = 1'b1;
        cyc();
        key_down[2] = 1'b0;
        repeat (14) cyc();
        key_down[0] = 1'b1;
        cyc();
        key_down[0] = 1'b0;
        cyc();
        mode = SEQ_STOP;
        cyc();
        n_tests++;
        if (event_count !== 3'd2 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_record: got count=%0d busy=%b expected count=2 busy=0", event_count, busy);
        end
        run_play(SEQ_PLAY, 3, 100);
        n_tests++;
        if (play_timeout || ev_voice.size() != 2 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_play_len: got events=%0d timeout=%b busy=%b expected 2 events then idle",
                     ev_voice.size(), play_timeout, busy);
        end
        for (int i = 0; i < 2 && i < ev_voice.size(); i++) begin
            n_tests++;
            if (ev_voice[i] != exp_v[i] || ev_cyc[i] != exp_c[i]) begin
                n_fail++;
                $display("FAIL single_event%0d: got voice=%0d cycle=%0d expected voice=%0d cycle=%0d",
                         i, ev_voice[i], ev_cyc[i], exp_v[i], exp_c[i]);
            end
        end
        mode = SEQ_STOP;
    endtask

    task automatic test_simultaneous();
        int exp_v[3] = '{0, 1, 3};
        int exp_c[3] = '{8, 11, 14};
        start_mode(SEQ_REC);
        repeat (7) cyc();
        key_down = 4'b1011;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            n_tests++;
            if (event_count !== 3'(k)) begin
                n_fail++;
                $display("FAIL simul_count_step%0d: got %0d expected %0d", k, event_count, k);
            end
        end
        key_down = '0;
        cyc();
        mode = SEQ_STOP;
        cyc();
        run_play(SEQ_PLAY, 4, 100);
        n_tests++;
        if (play_timeout || ev_voice.size() != 3) begin
            n_fail++;
            $display("FAIL simul_play_len: got events=%0d timeout=%b expected 3", ev_voice.size(), play_timeout);
        end
        for (int i = 0; i < 3 && i < ev_voice.size(); i++) begin
            n_tests++;
            if (ev_voice[i] != exp_v[i] || ev_cyc[i] != exp_c[i]) begin
                n_fail++;
                $display("FAIL simul_event%0d: got voice=%0d cycle=%0d expected voice=%0d cycle=%0d",
                         i, ev_voice[i], ev_cyc[i], exp_v[i], exp_c[i]);
            end
        end
        mode = SEQ_STOP;
    endtask

    // Uses the three entries left by test_simultaneous (voices 0, 1, 3 at ts 7).
    task automatic test_backpressure();
        int wait_c = 0;
        int unstable = 0;
        trig_if.trig_ready = 1'b0;
        start_mode(SEQ_PLAY);
        while (!trig_if.trig_valid && wait_c < 50) begin
            cyc();
            wait_c++;
        end
        n_tests++;
        if (wait_c != 8 || trig_if.trig_voice !== 2'd0) begin
            n_fail++;
            $display("FAIL bp_first_valid: got cycle=%0d voice=%0d expected cycle=8 voice=0",
                     wait_c, trig_if.trig_voice);
        end
        repeat (20) begin
            cyc();
            if (trig_if.trig_valid !== 1'b1 || trig_if.trig_voice !== 2'd0) unstable++;
        end
        n_tests++;
        if (unstable != 0) begin
            n_fail++;
            $display("FAIL bp_stable: got %0d unstable cycles expected 0", unstable);
        end
        trig_if.trig_ready = 1'b1;
        cyc();
        trig_if.trig_ready = 1'b0;
        n_tests++;
        if (trig_if.trig_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_accept: got valid=%b busy=%b expected valid=0 busy=1", trig_if.trig_valid, busy);
        end
        repeat (2) cyc();
        n_tests++;
        if (trig_if.trig_valid !== 1'b1 || trig_if.trig_voice !== 2'd1) begin
            n_fail++;
            $display("FAIL bp_next_event: got valid=%b voice=%0d expected valid=1 voice=1",
                     trig_if.trig_valid, trig_if.trig_voice);
        end
        mode = SEQ_STOP;
        cyc();
        n_tests++;
        if (trig_if.trig_valid !== 1'b0 || busy !== 1'b0 || trig_if.trig_voice !== 2'd0) begin
            n_fail++;
            $display("FAIL bp_abort: got valid=%b busy=%b voice=%0d expected 0 0 0",
                     trig_if.trig_valid, busy, trig_if.trig_voice);
        end
        trig_if.trig_ready = 1'b1;
    endtask

    task automatic test_loop();
        int exp_c[6] = '{4, 7, 12, 15, 20, 23};
        int wait_c = 0;
        start_mode(SEQ_REC);
        repeat (3) cyc();
        key_down[1] = 1'b1;
        repeat (2) cyc();
        key_down[2] = 1'b1;
        cyc();
        key_down = '0;
        mode = SEQ_STOP;
        cyc();
        n_tests++;
        if (event_count !== 3'd2) begin
            n_fail++;
            $display("FAIL loop_record: got count=%0d expected 2", event_count);
        end
        run_play(SEQ_LOOP, 6, 100);
        n_tests++;
        if (play_timeout || ev_voice.size() != 6 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL loop_len: got events=%0d timeout=%b busy=%b expected 6 events still busy",
                     ev_voice.size(), play_timeout, busy);
        end
        for (int i = 0; i < 6 && i < ev_voice.size(); i++) begin
            n_tests++;
            if (ev_voice[i] != ((i % 2 == 0) ? 1 : 2) || ev_cyc[i] != exp_c[i]) begin
                n_fail++;
                $display("FAIL loop_event%0d: got voice=%0d cycle=%0d expected voice=%0d cycle=%0d",
                         i, ev_voice[i], ev_cyc[i], (i % 2 == 0) ? 1 : 2, exp_c[i]);
            end
        end
        cyc();
        trig_if.trig_ready = 1'b0;
        while (!trig_if.trig_valid && wait_c < 20) begin
            cyc();
            wait_c++;
        end
        n_tests++;
        if (trig_if.trig_valid !== 1'b1 || trig_if.trig_voice !== 2'd1) begin
            n_fail++;
            $display("FAIL loop_fourth_pass: got valid=%b voice=%0d expected valid=1 voice=1",
                     trig_if.trig_valid, trig_if.trig_voice);
        end
        mode = SEQ_STOP;
        cyc();
        n_tests++;
        if (trig_if.trig_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL loop_abort: got valid=%b busy=%b expected 0 0", trig_if.trig_valid, busy);
        end
        trig_if.trig_ready = 1'b1;
    endtask

    task automatic test_overflow();
        start_mode(SEQ_REC);
        for (int i = 0; i < 5; i++) begin
            key_down[0] = 1'b1;
            cyc();
            key_down[0] = 1'b0;
            cyc();
            if (i == 3) begin
                n_tests++;
                if (event_count !== 3'd4 || overflow !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ovf_full: got count=%0d ovf=%b expected count=4 ovf=0", event_count, overflow);
                end
            end
        end
        n_tests++;
        if (event_count !== 3'd4 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_drop: got count=%0d ovf=%b expected count=4 ovf=1", event_count, overflow);
        end
        mode = SEQ_STOP;
        cyc();
        start_mode(SEQ_REC);
        n_tests++;
        if (event_count !== 3'd0 || overflow !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_clear: got count=%0d ovf=%b busy=%b expected 0 0 1", event_count, overflow, busy);
        end
        mode = SEQ_STOP;
        cyc();
        start_mode(SEQ_PLAY);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL play_empty: got busy=%b expected 0", busy);
        end
        mode = SEQ_STOP;
    endtask

    // No tick during recording: the onset must be stored with timestamp 0.
    task automatic test_tick_gate();
        tick = 1'b0;
        start_mode(SEQ_REC);
        repeat (20) cyc();
        key_down[1] = 1'b1;
        cyc();
        key_down = '0;
        mode = SEQ_STOP;
        cyc();
        tick = 1'b1;
        run_play(SEQ_PLAY, 2, 100);
        n_tests++;
        if (play_timeout || ev_voice.size() != 1 || ev_voice[0] != 1 || ev_cyc[0] != 2) begin
            n_fail++;
            $display("FAIL tick_gate: got events=%0d first_cycle=%0d expected 1 event voice 1 at cycle 2",
                     ev_voice.size(), (ev_cyc.size() > 0) ? ev_cyc[0] : -1);
        end
        mode = SEQ_STOP;
    endtask

    // Onset at cycle 300 with 8-bit timestamps records 255, not a wrapped value.
    task automatic test_saturation();
        start_mode(SEQ_REC);
        repeat (300) cyc();
        key_down[3] = 1'b1;
        cyc();
        key_down = '0;
        mode = SEQ_STOP;
        cyc();
        run_play(SEQ_PLAY, 2, 400);
        n_tests++;
        if (play_timeout || ev_voice.size() != 1 || ev_voice[0] != 3 || ev_cyc[0] != 256) begin
            n_fail++;
            $display("FAIL ts_saturate: got events=%0d first_cycle=%0d expected 1 event voice 3 at cycle 256",
                     ev_voice.size(), (ev_cyc.size() > 0) ? ev_cyc[0] : -1);
        end
        mode = SEQ_STOP;
    endtask

    task automatic test_reset_mid_record();
        start_mode(SEQ_REC);
        repeat (2) cyc();
        key_down[0] = 1'b1;
        repeat (2) cyc();
        key_down[1] = 1'b1;
        repeat (2) cyc();
        n_tests++;
        if (event_count !== 3'd2) begin
            n_fail++;
            $display("FAIL rst_pre_count: got %0d expected 2", event_count);
        end
        reset = 1'b1;
        start = 1'b1;
        cyc();
        reset = 1'b0;
        start = 1'b0;
        mode  = SEQ_STOP;
        key_down = '0;
        n_tests++;
        if ({busy, trig_if.trig_valid, trig_if.trig_voice, event_count, overflow} !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_mid_record: got busy=%b valid=%b voice=%0d count=%0d ovf=%b expected all 0",
                     busy, trig_if.trig_valid, trig_if.trig_voice, event_count, overflow);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_loop();
        test_overflow();
        test_tick_gate();
        test_saturation();
        test_reset_mid_record();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
